// File: rtl/i2c_pkg.sv
// Shared I2C definitions: state encodings for the slave and master
// controllers plus the default own-address of the slave.
package i2c_pkg;

    // Default 7-bit bus address answered by the slave.
    localparam logic [6:0] I2C_DEFAULT_SLAVE_ADDR = 7'h50;

    // Slave controller states.
    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        ADDR      = 4'd1,
        ADDR_ACK  = 4'd2,
        RX_BYTE   = 4'd3,
        RX_ACK    = 4'd4,
        TX_BYTE   = 4'd5,
        TX_ACK    = 4'd6,
        WAIT_STOP = 4'd7
    } i2c_slave_state_e;

    // Master controller states.
    typedef enum logic [3:0] {
        M_IDLE     = 4'd0,
        M_START    = 4'd1,
        M_ADDR     = 4'd2,
        M_ADDR_ACK = 4'd3,
        M_WR_BYTE  = 4'd4,
        M_WR_ACK   = 4'd5,
        M_RD_BYTE  = 4'd6,
        M_RD_ACK   = 4'd7,
        M_STOP     = 4'd8
    } i2c_master_state_e;

    // Narrow a small elaboration-time count to the 4-bit bit counter width.
    function automatic logic [3:0] to_cnt(input int n);
        return n[3:0];
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Brings SCL/SDA into the clk domain (two flops each), keeps one more
// registered copy, and flags SCL edges plus START/STOP conditions.
module i2c_bus_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic scl,
    input  logic sda_in,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    // Lane 0 = SCL, lane 1 = SDA.
    logic [1:0] pin;
    logic [1:0] meta_reg;
    logic [1:0] sync_reg;
    logic [1:0] prev_reg;
    logic [2:0] warm_reg;
    logic       events_en;

    assign pin = {sda_in, scl};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            // Two-flop synchroniser followed by the edge-detect copy; idles high.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    meta_reg[gi] <= 1'b1;
                    sync_reg[gi] <= 1'b1;
                    prev_reg[gi] <= 1'b1;
                end else begin
                    meta_reg[gi] <= pin[gi];
                    sync_reg[gi] <= meta_reg[gi];
                    prev_reg[gi] <= sync_reg[gi];
                end
            end
        end
    endgenerate

    // Hold events off until the chains are filled with real pin samples, so a
    // low bus line after reset cannot masquerade as a START or an SCL edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            warm_reg <= 3'b000;
        end else begin
            warm_reg <= {warm_reg[1:0], 1'b1};
        end
    end

    assign events_en = warm_reg[2];
    assign sda       = sync_reg[1];
    assign scl_rise  = events_en &  sync_reg[0] & ~prev_reg[0];
    assign scl_fall  = events_en & ~sync_reg[0] &  prev_reg[0];
    assign start     = events_en &  sync_reg[0] &  prev_reg[1] & ~sync_reg[1];
    assign stop      = events_en &  sync_reg[0] & ~prev_reg[1] &  sync_reg[1];

endmodule

// File: rtl/i2c_slave_ctrl.sv
// I2C slave protocol engine: address match, write-byte reception with ACK,
// read-byte transmission from a valid/ready source, open-drain SDA drive.
module i2c_slave_ctrl
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = I2C_DEFAULT_SLAVE_ADDR,
    parameter int         ADDR_LEN   = 7,
    parameter int         DATA_LEN   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                scl,
    input  logic                sda_in,
    output logic                sda_oe,
    input  logic [DATA_LEN-1:0] tx_data,
    input  logic                tx_valid,
    output logic                tx_ready,
    output logic [DATA_LEN-1:0] rx_data,
    output logic                rx_valid,
    output logic                rw,
    output logic                busy
);

    localparam logic [ADDR_LEN-1:0] OWN_ADDR  = ADDR_LEN'(SLAVE_ADDR);
    localparam logic [3:0]          ADDR_LAST = to_cnt(ADDR_LEN);
    localparam logic [3:0]          DATA_LAST = to_cnt(DATA_LEN - 1);
    localparam logic [3:0]          DATA_DONE = to_cnt(DATA_LEN);

    logic bus_sda;
    logic bus_scl_rise;
    logic bus_scl_fall;
    logic bus_start;
    logic bus_stop;

    i2c_slave_state_e      state_reg;
    logic [3:0]            bit_cnt_reg;
    logic [ADDR_LEN-1:0]   addr_shift_reg;
    logic [DATA_LEN-2:0]   rx_shift_reg;
    logic [DATA_LEN-1:0]   tx_shift_reg;

    logic [ADDR_LEN-1:0]   addr_next;
    logic [DATA_LEN-1:0]   rx_next;
    logic [DATA_LEN-1:0]   tx_load;

    i2c_bus_sync u_bus_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl      (scl),
        .sda_in   (sda_in),
        .sda      (bus_sda),
        .scl_rise (bus_scl_rise),
        .scl_fall (bus_scl_fall),
        .start    (bus_start),
        .stop     (bus_stop)
    );

    assign addr_next = {addr_shift_reg[ADDR_LEN-2:0], bus_sda};
    assign rx_next   = {rx_shift_reg, bus_sda};
    // With nothing queued the slave answers with an all-ones byte (SDA released).
    assign tx_load   = tx_valid ? tx_data : {DATA_LEN{1'b1}};

    // Protocol FSM: START/STOP override everything, otherwise SDA is sampled
    // on SCL rise and the open-drain drive only changes on SCL fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            bit_cnt_reg    <= 4'd0;
            addr_shift_reg <= '0;
            rx_shift_reg   <= '0;
            tx_shift_reg   <= '0;
            sda_oe         <= 1'b0;
            tx_ready       <= 1'b0;
            rx_valid       <= 1'b0;
            rx_data        <= '0;
            rw             <= 1'b0;
            busy           <= 1'b0;
        end else begin
            tx_ready <= 1'b0;
            rx_valid <= 1'b0;
            if (bus_start) begin
                state_reg   <= ADDR;
                bit_cnt_reg <= 4'd0;
                sda_oe      <= 1'b0;
                busy        <= 1'b1;
            end else if (bus_stop) begin
                state_reg   <= IDLE;
                bit_cnt_reg <= 4'd0;
                sda_oe      <= 1'b0;
                busy        <= 1'b0;
            end else begin
                case (state_reg)
                    ADDR: begin
                        if (bus_scl_rise) begin
                            if (bit_cnt_reg == ADDR_LAST) begin
                                rw          <= bus_sda;
                                bit_cnt_reg <= 4'd0;
                                state_reg   <= (addr_shift_reg == OWN_ADDR) ? ADDR_ACK : WAIT_STOP;
                            end else begin
                                addr_shift_reg <= addr_next;
                                bit_cnt_reg    <= bit_cnt_reg + 4'd1;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        // First fall pulls SDA low; the fall after the ACK clock moves on.
                        if (bus_scl_fall) begin
                            if (bit_cnt_reg == 4'd0) begin
                                sda_oe <= 1'b1;
                            end else begin
                                bit_cnt_reg <= 4'd0;
                                if (rw) begin
                                    state_reg    <= TX_BYTE;
                                    sda_oe       <= ~tx_load[DATA_LEN-1];
                                    tx_shift_reg <= {tx_load[DATA_LEN-2:0], 1'b0};
                                    tx_ready     <= tx_valid;
                                end else begin
                                    state_reg <= RX_BYTE;
                                    sda_oe    <= 1'b0;
                                end
                            end
                        end else if (bus_scl_rise) begin
                            bit_cnt_reg <= 4'd1;
                        end
                    end
                    RX_BYTE: begin
                        if (bus_scl_rise) begin
                            if (bit_cnt_reg == DATA_LAST) begin
                                rx_data     <= rx_next;
                                rx_valid    <= 1'b1;
                                bit_cnt_reg <= 4'd0;
                                state_reg   <= RX_ACK;
                            end else begin
                                rx_shift_reg <= rx_next[DATA_LEN-2:0];
                                bit_cnt_reg  <= bit_cnt_reg + 4'd1;
                            end
                        end
                    end
                    RX_ACK: begin
                        if (bus_scl_fall) begin
                            if (bit_cnt_reg == 4'd0) begin
                                sda_oe <= 1'b1;
                            end else begin
                                sda_oe      <= 1'b0;
                                bit_cnt_reg <= 4'd0;
                                state_reg   <= RX_BYTE;
                            end
                        end else if (bus_scl_rise) begin
                            bit_cnt_reg <= 4'd1;
                        end
                    end
                    TX_BYTE: begin
                        // The MSB was already placed on entry; each fall presents the next bit.
                        if (bus_scl_rise) begin
                            bit_cnt_reg <= bit_cnt_reg + 4'd1;
                        end else if (bus_scl_fall) begin
                            if (bit_cnt_reg == DATA_DONE) begin
                                sda_oe      <= 1'b0;
                                bit_cnt_reg <= 4'd0;
                                state_reg   <= TX_ACK;
                            end else begin
                                sda_oe       <= ~tx_shift_reg[DATA_LEN-1];
                                tx_shift_reg <= {tx_shift_reg[DATA_LEN-2:0], 1'b0};
                            end
                        end
                    end
                    TX_ACK: begin
                        if (bus_scl_rise) begin
                            if (bus_sda) begin
                                state_reg   <= WAIT_STOP;
                                bit_cnt_reg <= 4'd0;
                            end else begin
                                bit_cnt_reg <= 4'd1;
                            end
                        end else if (bus_scl_fall && bit_cnt_reg == 4'd1) begin
                            state_reg    <= TX_BYTE;
                            bit_cnt_reg  <= 4'd0;
                            sda_oe       <= ~tx_load[DATA_LEN-1];
                            tx_shift_reg <= {tx_load[DATA_LEN-2:0], 1'b0};
                            tx_ready     <= tx_valid;
                        end
                    end
                    default: begin
                        // IDLE and WAIT_STOP only leave on START/STOP.
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Directed bench for i2c_slave_ctrl: a bit-banged I2C master drives the
// bus through an open-drain wired-AND model of SDA.
module tb_i2c_slave_ctrl;

    localparam int Q = 8;   // clk cycles per quarter SCL period

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_in;
    logic       sda_oe;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rw;
    logic       busy;

    int errors = 0;
    int checks = 0;
    int rx_pulses = 0;
    int tx_pulses = 0;
    int oe_cycles = 0;

    assign sda_in = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_slave_ctrl #(
        .SLAVE_ADDR (7'h50),
        .ADDR_LEN   (7),
        .DATA_LEN   (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl      (scl),
        .sda_in   (sda_in),
        .sda_oe   (sda_oe),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rw       (rw),
        .busy     (busy)
    );

    // Count pulse-high cycles away from the active edge.
    always @(negedge clk) begin
        if (rx_valid) rx_pulses <= rx_pulses + 1;
        if (tx_ready) tx_pulses <= tx_pulses + 1;
        if (sda_oe)   oe_cycles <= oe_cycles + 1;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wait_q();
        scl   = 1'b1; wait_q();
        sda_m = 1'b0; wait_q();
        scl   = 1'b0; wait_q();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_q();
        scl   = 1'b1; wait_q();
        sda_m = 1'b1; wait_q();
    endtask

    task automatic write_bit(input logic b);
        sda_m = b;    wait_q();
        scl   = 1'b1; wait_q(); wait_q();
        scl   = 1'b0; wait_q();
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; wait_q();
        scl   = 1'b1; wait_q();
        b     = sda_in; wait_q();
        scl   = 1'b0; wait_q();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d);
        logic b;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            read_bit(b);
            d = {d[6:0], b};
        end
    endtask

    typedef struct {
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       txv;
        logic [7:0] txd;
        logic       exp_ack;    // 0 = slave ACKs the address
        logic [7:0] exp_rd;
        logic [7:0] exp_rx;
        int         exp_rxp;
        int         exp_txp;
        logic       exp_oe;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic       ack;
        logic [7:0] rd;
        int         rx0, tx0, oe0;

        //           addr   wdata  txv   txd    ack   rd     rx     rxp txp oe
        vecs[0] = '{8'hA0, 8'h3C, 1'b0, 8'h00, 1'b0, 8'h00, 8'h3C, 1, 0, 1'b1};
        vecs[1] = '{8'hA1, 8'h00, 1'b1, 8'h96, 1'b0, 8'h96, 8'h3C, 0, 1, 1'b1};
        vecs[2] = '{8'hA2, 8'h55, 1'b0, 8'h00, 1'b1, 8'h00, 8'h3C, 0, 0, 1'b0};
        vecs[3] = '{8'hA1, 8'h00, 1'b0, 8'h5A, 1'b0, 8'hFF, 8'h3C, 0, 0, 1'b1};
        vecs[4] = '{8'hA0, 8'hC3, 1'b0, 8'h00, 1'b0, 8'h00, 8'hC3, 1, 0, 1'b1};
        vecs[5] = '{8'hA3, 8'h00, 1'b1, 8'h77, 1'b1, 8'hFF, 8'hC3, 0, 0, 1'b0};

        // Reset state
        #1;
        check("rst_sda_oe",   32'(sda_oe),   32'h0);
        check("rst_tx_ready", 32'(tx_ready), 32'h0);
        check("rst_rx_valid", 32'(rx_valid), 32'h0);
        check("rst_rx_data",  32'(rx_data),  32'h0);
        check("rst_rw",       32'(rw),       32'h0);
        check("rst_busy",     32'(busy),     32'h0);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        wait_q(); wait_q();

        // Table-driven frames
        for (int i = 0; i < 6; i++) begin
            tx_data  = vecs[i].txd;
            tx_valid = vecs[i].txv;
            rx0 = rx_pulses; tx0 = tx_pulses; oe0 = oe_cycles;
            i2c_start();
            check($sformatf("v%0d_busy_in_frame", i), 32'(busy), 32'h1);
            write_byte(vecs[i].addr, ack);
            check($sformatf("v%0d_addr_ack", i), 32'(ack), 32'(vecs[i].exp_ack));
            if (!vecs[i].addr[0]) begin
                write_byte(vecs[i].wdata, ack);
                check($sformatf("v%0d_data_ack", i), 32'(ack), 32'(vecs[i].exp_ack));
            end else begin
                read_byte(rd);
                write_bit(1'b1);
                check($sformatf("v%0d_read_byte", i), 32'(rd), 32'(vecs[i].exp_rd));
                read_byte(rd);
                write_bit(1'b1);
                check($sformatf("v%0d_after_nack", i), 32'(rd), 32'hFF);
            end
            i2c_stop();
            wait_q();
            check($sformatf("v%0d_busy_after_stop", i), 32'(busy), 32'h0);
            check($sformatf("v%0d_rw", i), 32'(rw), 32'(vecs[i].addr[0]));
            check($sformatf("v%0d_rx_data", i), 32'(rx_data), 32'(vecs[i].exp_rx));
            check($sformatf("v%0d_rx_pulses", i), 32'(rx_pulses - rx0), 32'(vecs[i].exp_rxp));
            check($sformatf("v%0d_tx_pulses", i), 32'(tx_pulses - tx0), 32'(vecs[i].exp_txp));
            check($sformatf("v%0d_oe_used", i), 32'(oe_cycles != oe0), 32'(vecs[i].exp_oe));
            $display("frame %0d: addr=0x%02h rw=%0b rx_data=0x%02h rx_pulses=%0d tx_pulses=%0d",
                     i, vecs[i].addr, rw, rx_data, rx_pulses - rx0, tx_pulses - tx0);
        end

        // Repeated START: write 0x11, then re-address for a read
        tx_data = 8'h5A; tx_valid = 1'b1;
        rx0 = rx_pulses; tx0 = tx_pulses;
        i2c_start();
        write_byte(8'hA0, ack);
        check("rs_addr_ack", 32'(ack), 32'h0);
        write_byte(8'h11, ack);
        check("rs_data_ack", 32'(ack), 32'h0);
        check("rs_rx_data", 32'(rx_data), 32'h11);
        i2c_start();
        check("rs_busy", 32'(busy), 32'h1);
        write_byte(8'hA1, ack);
        check("rs_read_addr_ack", 32'(ack), 32'h0);
        check("rs_rw", 32'(rw), 32'h1);
        read_byte(rd);
        write_bit(1'b1);
        check("rs_read_byte", 32'(rd), 32'h5A);
        i2c_stop();
        wait_q();
        check("rs_rx_pulses", 32'(rx_pulses - rx0), 32'h1);
        check("rs_tx_pulses", 32'(tx_pulses - tx0), 32'h1);
        $display("repeated start: rx_data=0x%02h read=0x%02h", rx_data, rd);

        // Reset during bit 4 of a read byte while the slave is pulling SDA low
        tx_data = 8'h00; tx_valid = 1'b1;
        i2c_start();
        write_byte(8'hA1, ack);
        check("mr_addr_ack", 32'(ack), 32'h0);
        for (int i = 0; i < 3; i++) read_bit(ack);
        check("mr_oe_before_rst", 32'(sda_oe), 32'h1);
        rst_n = 1'b0;
        #1;
        check("mr_oe_in_rst",   32'(sda_oe),  32'h0);
        check("mr_busy_in_rst", 32'(busy),    32'h0);
        check("mr_rx_data_rst", 32'(rx_data), 32'h0);
        check("mr_rw_rst",      32'(rw),      32'h0);
        wait_q();
        rst_n = 1'b1;
        oe0 = oe_cycles; rx0 = rx_pulses; tx0 = tx_pulses;
        for (int i = 0; i < 5; i++) read_bit(ack);
        write_bit(1'b1);
        check("mr_ignored_oe", 32'(oe_cycles - oe0), 32'h0);
        check("mr_ignored_busy", 32'(busy), 32'h0);
        i2c_stop();
        wait_q();
        i2c_start();
        write_byte(8'hA0, ack);
        check("mr_next_addr_ack", 32'(ack), 32'h0);
        write_byte(8'h5A, ack);
        check("mr_next_data_ack", 32'(ack), 32'h0);
        i2c_stop();
        wait_q();
        check("mr_next_rx_data", 32'(rx_data), 32'h5A);
        check("mr_rx_pulses", 32'(rx_pulses - rx0), 32'h1);
        check("mr_tx_pulses", 32'(tx_pulses - tx0), 32'h0);
        $display("reset mid-byte: next frame rx_data=0x%02h busy=%0b", rx_data, busy);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2c_slave_ctrl.md
I2C_SLAVE_CTRL -- requirements
Module: i2c_slave_ctrl

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h50, meaning 7-bit own bus address.
REQ-002 SHALL have parameter ADDR_LEN, default 7, meaning address bits per frame.
REQ-003 SHALL have parameter DATA_LEN, default 8, meaning data bits per byte.
REQ-004 SHALL have port clk  input  1  system clock; all logic on posedge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port scl  input  1  bus clock from master, asynchronous to clk.
REQ-007 SHALL have port sda_in  input  1  bus data line level, asynchronous to clk.
REQ-008 SHALL have port sda_oe  output  1  open-drain pull-low enable; 1 = drive SDA low.
REQ-009 SHALL have port tx_data  input  DATA_LEN  byte to return on a read.
REQ-010 SHALL have port tx_valid  input  1  tx_data holds a valid byte.
REQ-011 SHALL have port tx_ready  output  1  one-cycle pulse: tx_data consumed.
REQ-012 SHALL have port rx_data  output  DATA_LEN  last byte received on a write.
REQ-013 SHALL have port rx_valid  output  1  one-cycle pulse: rx_data updated.
REQ-014 SHALL have port rw  output  1  R/W bit of current frame; 1 = read.
REQ-015 SHALL have port busy  output  1  high from START to STOP.

Function
REQ-016 SHALL synchronise scl and sda_in through 2 flops each, then take one registered copy for edge detection; bus events act 3 clk after the pin change.
REQ-017 SHALL detect START as synced SDA falling while synced SCL is high, and STOP as synced SDA rising while synced SCL is high.
REQ-018 SHALL use states IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, WAIT_STOP.
REQ-019 SHALL sample SDA only on synced SCL rising edges, and change sda_oe only on synced SCL falling edges.
REQ-020 SHALL go from any state to ADDR on START (including repeated START), clearing the bit counter and releasing sda_oe.
REQ-021 SHALL go from any state to IDLE on STOP, setting sda_oe=0 and busy=0.
REQ-022 ADDR SHALL shift in ADDR_LEN+1 bits MSB-first; the last bit is latched into rw.
REQ-023 On address match, SHALL assert sda_oe on the next SCL fall (ADDR_ACK); on mismatch, SHALL go to WAIT_STOP and never drive.
REQ-024 After the ACK bit, on the SCL fall, SHALL go to RX_BYTE if rw=0 and release sda_oe.
REQ-025 After the ACK bit, on the SCL fall, SHALL go to TX_BYTE if rw=1.
REQ-026 RX_BYTE SHALL shift DATA_LEN bits MSB-first; on the last rising edge it SHALL load rx_data and pulse rx_valid for 1 clk.
REQ-027 RX_ACK SHALL drive ACK for one SCL period, then return to RX_BYTE.
REQ-028 On entering TX_BYTE, SHALL load tx_data if tx_valid=1 and pulse tx_ready; else SHALL load 8'hFF and not pulse tx_ready.
REQ-029 TX_BYTE SHALL set sda_oe = ~bit, MSB first, with each bit updated on an SCL fall.
REQ-030 After DATA_LEN bits, TX_ACK SHALL release sda_oe and sample master ACK on the rising edge.
REQ-031 TX_ACK with ACK (0) SHALL continue with a new TX_BYTE.
REQ-032 TX_ACK with NACK (1) SHALL go to WAIT_STOP.
REQ-033 The bit counter SHALL be 4 bits wide, count from 0, wrap to 0 at each byte/ACK boundary, and never overflow.
REQ-034 If START and STOP are flagged in the same clk (not possible with a single SDA edge), START SHALL win.

Reset
REQ-035 On rst_n low, SHALL immediately set state=IDLE, sda_oe=0, tx_ready=0, rx_valid=0, rx_data=0, rw=0, busy=0, synchroniser flops=1.
REQ-036 Reset deassertion mid-transfer SHALL leave the block in IDLE, ignoring bus activity until the next START.

Structure
REQ-037 State encoding and default SLAVE_ADDR SHALL live in the shared i2c package alongside the master state codes.
REQ-038 The synchroniser plus START/STOP/edge detector SHALL be a sub-module named i2c_bus_sync.

Verification
REQ-039 Scenario: write 0xA0 then 0x3C, STOP -> ACK on address and data, rx_data=0x3C, one rx_valid pulse, busy low after STOP.
REQ-040 Scenario: read 0xA1 with tx_data=0x96 and tx_valid=1, master NACK -> SDA bits 1,0,0,1,0,1,1,0, one tx_ready pulse, then WAIT_STOP.
REQ-041 Scenario: address 0xA2 (0x51) -> sda_oe stays 0 for the whole frame and rx_valid never pulses.
REQ-042 Scenario: repeated START after write byte 0x11, then 0xA1 read -> rx_data=0x11 and TX_BYTE entered.
REQ-043 Scenario: read with tx_valid=0 -> 0xFF is transmitted and tx_ready does not pulse.
REQ-044 Scenario: rst_n pulsed low during bit 4 of a data byte -> sda_oe=0 immediately, and the next frame 0xA0 is ACKed normally.
